// File: rtl/ap_txn_profiler.sv
// Transaction profiler for a non-dataflow HLS top: watches the block-level handshake and the
// one-hot FSM, and queues one {id, latency, iterations, worst iteration} record per transaction.
`timescale 1ns/1ps
module ap_txn_profiler #(
  parameter int NSTATE     = 85,
  parameter int ITER_START = 1,
  parameter int ITER_END   = 84,
  parameter int CW         = 32,
  parameter int DEPTH      = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_continue,
  input  logic [NSTATE-1:0] cur_state,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [15:0]       rec_id,
  output logic [CW-1:0]     rec_latency,
  output logic [CW-1:0]     rec_iters,
  output logic [CW-1:0]     rec_max_iter,
  output logic [15:0]       drop_cnt,
  output logic              overflow,
  output logic              proto_err
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;
  localparam int RW   = 16 + 3 * CW;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  // ap_ready and the non-loop state bits are deliberately ignored.
  logic w_unused;
  assign w_unused = ^{ap_ready, cur_state};

  // Asynchronous assertion, deassertion re-timed onto ap_clk.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  state_t r_state, w_state_next;
  logic   w_start, w_complete, w_proto;

  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    w_proto      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_proto = ap_done;
        if (ap_start) begin
          w_start      = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (ap_done && ap_continue) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  logic          w_start_bit, w_end_bit, r_prev_start, r_prev_end;
  logic          w_iter_open_evt, w_iter_close_evt, w_fold;
  logic [CW-1:0] r_lat_cnt, r_iters, r_max_iter, r_iter_cyc;
  logic          r_iter_open, r_proto_err;
  logic [15:0]   r_txn_id;

  assign w_start_bit      = cur_state[ITER_START];
  assign w_end_bit        = cur_state[ITER_END];
  assign w_iter_open_evt  = (r_state == S_RUN) && w_start_bit && !r_prev_start;
  assign w_iter_close_evt = (r_state == S_RUN) && r_iter_open && r_prev_end && !w_end_bit;
  // A new entry while an iteration is still open closes that iteration first.
  assign w_fold           = w_iter_close_evt || (w_iter_open_evt && r_iter_open);

  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_prev_start <= 1'b0;
      r_prev_end   <= 1'b0;
      r_lat_cnt    <= '0;
      r_iters      <= '0;
      r_max_iter   <= '0;
      r_iter_cyc   <= '0;
      r_iter_open  <= 1'b0;
      r_txn_id     <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_prev_start <= w_start_bit;
      r_prev_end   <= w_end_bit;
      if (w_start) begin
        r_lat_cnt   <= CW'(1);
        r_iters     <= '0;
        r_max_iter  <= '0;
        r_iter_cyc  <= '0;
        r_iter_open <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_lat_cnt <= sat_inc(r_lat_cnt);
        if (w_fold && (r_iter_cyc > r_max_iter)) r_max_iter <= r_iter_cyc;
        if (w_iter_open_evt) begin
          r_iters     <= sat_inc(r_iters);
          r_iter_open <= 1'b1;
          r_iter_cyc  <= CW'(1);
        end else if (w_iter_close_evt) begin
          r_iter_open <= 1'b0;
        end else if (r_iter_open) begin
          r_iter_cyc <= sat_inc(r_iter_cyc);
        end
      end
      if (w_complete) r_txn_id <= r_txn_id + 16'd1;
      if (w_proto)    r_proto_err <= 1'b1;
    end
  end

  // Record FIFO; the output register is loaded with the entry that will be the head next cycle.
  logic [RW-1:0]   r_mem [DEPTH];
  logic [RW-1:0]   w_rec_din, w_head_next, r_rec_data;
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_next;
  logic [CNTW-1:0] r_count, w_count_next;
  logic            w_full, w_pop, w_push, w_drop, r_rec_valid, r_overflow;
  logic [15:0]     r_drop_cnt;

  assign w_rec_din     = {r_txn_id, sat_inc(r_lat_cnt), r_iters, r_max_iter};
  assign w_full        = (r_count == CNTW'(DEPTH));
  assign w_pop         = r_rec_valid && rec_ready;
  assign w_push        = w_complete && (!w_full || w_pop);
  assign w_drop        = w_complete && w_full && !w_pop;
  assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);
  assign w_count_next  = r_count + CNTW'(w_push) - CNTW'(w_pop);
  assign w_head_next   = (w_push && (r_wr_ptr == w_rd_ptr_next)) ? w_rec_din : r_mem[w_rd_ptr_next];

  always_ff @(posedge ap_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_rec_din;
  end

  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rec_valid <= 1'b0;
      r_rec_data  <= '0;
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_rec_valid <= (w_count_next != '0);
      if (w_count_next != '0) r_rec_data <= w_head_next;
      if (w_drop) begin
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        r_overflow <= 1'b1;
      end
    end
  end

  assign rec_valid = r_rec_valid;
  assign {rec_id, rec_latency, rec_iters, rec_max_iter} = r_rec_data;
  assign drop_cnt  = r_drop_cnt;
  assign overflow  = r_overflow;
  assign proto_err = r_proto_err;
endmodule
